// File: rtl/video_timing_if.sv
// Raster timing bundle: pixel clock enable in, counters/sync/strobes/delayed sync out.
interface video_timing_if #(
   parameter int CNT_W   = 11,
   parameter int FRAME_W = 16
);
   logic               ce;
   logic [CNT_W-1:0]   h_count;
   logic [CNT_W-1:0]   v_count;
   logic               hsync;
   logic               vsync;
   logic               de;
   logic               vblank;
   logic [CNT_W-1:0]   pixel_x;
   logic [CNT_W-1:0]   pixel_y;
   logic               line_start;
   logic               frame_start;
   logic [FRAME_W-1:0] frame_count;
   logic               hsync_d;
   logic               vsync_d;
   logic               de_d;

   modport master (
      input  ce,
      output h_count, v_count, hsync, vsync, de, vblank, pixel_x, pixel_y,
             line_start, frame_start, frame_count, hsync_d, vsync_d, de_d
   );

   modport slave (
      output ce,
      input  h_count, v_count, hsync, vsync, de, vblank, pixel_x, pixel_y,
             line_start, frame_start, frame_count, hsync_d, vsync_d, de_d
   );
endinterface

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: h/v counters, registered sync/DE/blanking,
// active-area coordinates, line/frame strobes, frame counter and a sync/DE delay line.
module video_timing_gen #(
   parameter int CNT_W      = 11,
   parameter int FRAME_W    = 16,
   parameter int H_ACTIVE   = 640,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BP       = 48,
   parameter int V_ACTIVE   = 480,
   parameter int V_FP       = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BP       = 33,
   parameter bit HSYNC_POL  = 1'b0,
   parameter bit VSYNC_POL  = 1'b0,
   parameter int PIPE_DELAY = 0
) (
   input logic           clk,
   input logic           rst_n,
   video_timing_if.master vt
);

   localparam int H_TOTAL = H_FP + H_SYNC + H_BP + H_ACTIVE;
   localparam int V_TOTAL = V_FP + V_SYNC + V_BP + V_ACTIVE;

   localparam logic [CNT_W-1:0] H_LAST      = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST      = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_SYNC_BEG  = CNT_W'(H_FP);
   localparam logic [CNT_W-1:0] H_SYNC_END  = CNT_W'(H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] H_ACT_BEG   = CNT_W'(H_FP + H_SYNC + H_BP);
   localparam logic [CNT_W-1:0] V_SYNC_BEG  = CNT_W'(V_FP);
   localparam logic [CNT_W-1:0] V_SYNC_END  = CNT_W'(V_FP + V_SYNC);
   localparam logic [CNT_W-1:0] V_ACT_BEG   = CNT_W'(V_FP + V_SYNC + V_BP);

   if (H_TOTAL >= (1 << CNT_W)) begin : g_h_total_too_wide
      $error("video_timing_gen: H_TOTAL does not fit in CNT_W bits");
   end
   if (V_TOTAL >= (1 << CNT_W)) begin : g_v_total_too_wide
      $error("video_timing_gen: V_TOTAL does not fit in CNT_W bits");
   end
   if (PIPE_DELAY < 0 || PIPE_DELAY > 15) begin : g_pipe_delay_range
      $error("video_timing_gen: PIPE_DELAY must be 0..15");
   end

   logic [CNT_W-1:0]   r_h;
   logic [CNT_W-1:0]   r_v;
   logic [FRAME_W-1:0] r_frame;
   logic               r_hsync;
   logic               r_vsync;
   logic               r_de;
   logic               r_vblank;
   logic [CNT_W-1:0]   r_px;
   logic [CNT_W-1:0]   r_py;
   logic               r_line_start;
   logic               r_frame_start;

   logic w_h_act;
   logic w_v_act;
   logic w_hs_on;
   logic w_vs_on;

   assign w_h_act = (r_h >= H_ACT_BEG);
   assign w_v_act = (r_v >= V_ACT_BEG);
   assign w_hs_on = (r_h >= H_SYNC_BEG) && (r_h < H_SYNC_END);
   assign w_vs_on = (r_v >= V_SYNC_BEG) && (r_v < V_SYNC_END);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_h     <= '0;
         r_v     <= '0;
         r_frame <= '0;
      end else if (vt.ce) begin
         if (r_h == H_LAST) begin
            r_h <= '0;
            if (r_v == V_LAST) begin
               r_v     <= '0;
               r_frame <= r_frame + 1'b1;
            end else begin
               r_v <= r_v + 1'b1;
            end
         end else begin
            r_h <= r_h + 1'b1;
         end
      end
   end

   // Decodes are taken from the counter value of the same ce-cycle, so they lag h/v by one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hsync       <= ~HSYNC_POL;
         r_vsync       <= ~VSYNC_POL;
         r_de          <= 1'b0;
         r_vblank      <= 1'b1;
         r_px          <= '0;
         r_py          <= '0;
         r_line_start  <= 1'b0;
         r_frame_start <= 1'b0;
      end else if (vt.ce) begin
         r_hsync       <= w_hs_on ? HSYNC_POL : ~HSYNC_POL;
         r_vsync       <= w_vs_on ? VSYNC_POL : ~VSYNC_POL;
         r_de          <= w_h_act && w_v_act;
         r_vblank      <= ~w_v_act;
         r_px          <= (w_h_act && w_v_act) ? (r_h - H_ACT_BEG) : '0;
         r_py          <= (w_h_act && w_v_act) ? (r_v - V_ACT_BEG) : '0;
         r_line_start  <= (r_h == '0);
         r_frame_start <= (r_h == '0) && (r_v == '0);
      end
   end

   assign vt.h_count     = r_h;
   assign vt.v_count     = r_v;
   assign vt.frame_count = r_frame;
   assign vt.hsync       = r_hsync;
   assign vt.vsync       = r_vsync;
   assign vt.de          = r_de;
   assign vt.vblank      = r_vblank;
   assign vt.pixel_x     = r_px;
   assign vt.pixel_y     = r_py;
   assign vt.line_start  = r_line_start;
   assign vt.frame_start = r_frame_start;

   if (PIPE_DELAY == 0) begin : g_no_delay
      assign vt.hsync_d = r_hsync;
      assign vt.vsync_d = r_vsync;
      assign vt.de_d    = r_de;
   end else begin : g_delay
      logic [PIPE_DELAY-1:0] r_hs_pipe;
      logic [PIPE_DELAY-1:0] r_vs_pipe;
      logic [PIPE_DELAY-1:0] r_de_pipe;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_hs_pipe <= {PIPE_DELAY{~HSYNC_POL}};
            r_vs_pipe <= {PIPE_DELAY{~VSYNC_POL}};
            r_de_pipe <= '0;
         end else if (vt.ce) begin
            r_hs_pipe[0] <= r_hsync;
            r_vs_pipe[0] <= r_vsync;
            r_de_pipe[0] <= r_de;
            for (int i = 1; i < PIPE_DELAY; i++) begin
               r_hs_pipe[i] <= r_hs_pipe[i-1];
               r_vs_pipe[i] <= r_vs_pipe[i-1];
               r_de_pipe[i] <= r_de_pipe[i-1];
            end
         end
      end

      assign vt.hsync_d = r_hs_pipe[PIPE_DELAY-1];
      assign vt.vsync_d = r_vs_pipe[PIPE_DELAY-1];
      assign vt.de_d    = r_de_pipe[PIPE_DELAY-1];
   end

endmodule
